// File: rtl/pe_pkg.sv
// pe_pkg: shared PE constants, algorithm select encoding and modulus lookup
package pe_pkg;
    localparam int Q_KYBER     = 3329;
    localparam int Q_DILITHIUM = 8380417;
    localparam int COEF_W      = 23;

    typedef enum logic {
        ALG_KYBER     = 1'b0,
        ALG_DILITHIUM = 1'b1
    } alg_t;

    function automatic logic [COEF_W-1:0] q_of(input alg_t alg);
        return (alg == ALG_DILITHIUM) ? COEF_W'(Q_DILITHIUM) : COEF_W'(Q_KYBER);
    endfunction
endpackage

// File: rtl/mod_addsub.sv
// mod_addsub: combinational (a+b) mod q and (a-b) mod q for Kyber or Dilithium q
module mod_addsub
    import pe_pkg::*;
#(
    parameter int W = COEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         select,
    output logic [W-1:0] sum_mod,
    output logic [W-1:0] diff_mod
);
    logic [W-1:0] am, bm, q;
    logic [W:0]   sum, diff;

    // Kyber operands live in the low 12 bits; one conditional correction each way
    always_comb begin
        q        = W'(q_of(alg_t'(select)));
        am       = select ? a : {{(W-12){1'b0}}, a[11:0]};
        bm       = select ? b : {{(W-12){1'b0}}, b[11:0]};
        sum      = {1'b0, am} + {1'b0, bm};
        diff     = {1'b0, am} - {1'b0, bm};
        sum_mod  = (sum >= {1'b0, q}) ? W'(sum - {1'b0, q}) : sum[W-1:0];
        diff_mod = diff[W] ? W'(diff + {1'b0, q}) : diff[W-1:0];
    end
endmodule

// File: rtl/ct_bfly_post.sv
// ct_bfly_post: two-stage valid/ready Cooley-Tukey butterfly (x=a+wb, y=a-wb mod q).
// Optional BFLY_HALVE_EN adds halve_i, scaling x and y by 2^-1 mod q for inverse NTT.
module ct_bfly_post
    import pe_pkg::*;
#(
    parameter int COEF_W = 23,
    parameter int TAG_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [COEF_W-1:0] a_i,
    input  logic [COEF_W-1:0] wb_i,
    input  logic              select_i,
    input  logic [TAG_W-1:0]  tag_i,
`ifdef BFLY_HALVE_EN
    input  logic              halve_i,
`endif
    output logic              valid_o,
    input  logic              ready_i,
    output logic [COEF_W-1:0] x_o,
    output logic [COEF_W-1:0] y_o,
    output logic              select_o,
    output logic [TAG_W-1:0]  tag_o
);
    logic              v1;
    logic [COEF_W-1:0] a1, wb1;
    logic              sel1;
    logic [TAG_W-1:0]  tag1;
    logic [COEF_W-1:0] xs, ys, xn, yn;
    logic              s1_load, s2_load;

    assign s2_load = !valid_o || ready_i;
    assign s1_load = !v1 || s2_load;
    assign ready_o = s1_load;

    mod_addsub #(.W(COEF_W)) u_addsub (
        .a        (a1),
        .b        (wb1),
        .select   (sel1),
        .sum_mod  (xs),
        .diff_mod (ys)
    );

`ifdef BFLY_HALVE_EN
    logic h1;

    function automatic logic [COEF_W-1:0] half(input logic [COEF_W-1:0] v, input logic sel);
        logic [COEF_W:0] t;
        t = {1'b0, v} + (v[0] ? {1'b0, COEF_W'(q_of(alg_t'(sel)))} : '0);
        return t[COEF_W:1];
    endfunction

    assign xn = h1 ? half(xs, sel1) : xs;
    assign yn = h1 ? half(ys, sel1) : ys;

    // halve flag travels alongside the S1 operands
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) h1 <= 1'b0;
        else if (s1_load && valid_i) h1 <= halve_i;
    end
`else
    assign xn = xs;
    assign yn = ys;
`endif

    // S1: capture operands whenever the stage is empty or draining into S2
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1   <= 1'b0;
            a1   <= '0;
            wb1  <= '0;
            sel1 <= 1'b0;
            tag1 <= '0;
        end else if (s1_load) begin
            v1 <= valid_i;
            if (valid_i) begin
                a1   <= a_i;
                wb1  <= wb_i;
                sel1 <= select_i;
                tag1 <= tag_i;
            end
        end
    end

    // S2: register butterfly results; data holds while the output is stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o  <= 1'b0;
            x_o      <= '0;
            y_o      <= '0;
            select_o <= 1'b0;
            tag_o    <= '0;
        end else if (s2_load) begin
            valid_o <= v1;
            if (v1) begin
                x_o      <= xn;
                y_o      <= yn;
                select_o <= sel1;
                tag_o    <= tag1;
            end
        end
    end
endmodule

// File: tb/tb_ct_bfly_post.sv
// tb_ct_bfly_post: directed and randomized checks of ct_bfly_post against a modular-arithmetic model
module tb_ct_bfly_post;
    localparam int CW = 23;
    localparam int TW = 8;
    localparam int QK = 3329;
    localparam int QD = 8380417;

    logic clk = 1'b0;
    logic rst_i = 1'b1, valid_i = 1'b0, ready_i = 1'b1, select_i = 1'b0, halve_i = 1'b0;
    logic [CW-1:0] a_i = '0, wb_i = '0;
    logic [TW-1:0] tag_i = '0;
    logic ready_o, valid_o, select_o;
    logic [CW-1:0] x_o, y_o;
    logic [TW-1:0] tag_o;

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          sel;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t q_exp[$];
    exp_t pending, held_v;
    bit   held = 0;
    int   checks = 0, errors = 0, consumed = 0;

    ct_bfly_post #(.COEF_W(CW), .TAG_W(TW)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .wb_i     (wb_i),
        .select_i (select_i),
        .tag_i    (tag_i),
`ifdef BFLY_HALVE_EN
        .halve_i  (halve_i),
`endif
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .x_o      (x_o),
        .y_o      (y_o),
        .select_o (select_o),
        .tag_o    (tag_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int a, input int wb, input bit sel, input bit h, input int tag);
        int q, x, y;
        exp_t e;
        q = sel ? QD : QK;
        x = (a + wb) % q;
        y = ((a - wb) % q + q) % q;
        if (h) begin
            x = (x % 2 == 0) ? x / 2 : (x + q) / 2;
            y = (y % 2 == 0) ? y / 2 : (y + q) / 2;
        end
        e.x = CW'(x);
        e.y = CW'(y);
        e.sel = sel;
        e.tag = TW'(tag);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int a, input int wb, input bit sel, input bit h, input int tag, input exp_t e);
        valid_i  = v;
        a_i      = CW'(a);
        wb_i     = CW'(wb);
        select_i = sel;
        halve_i  = h;
        tag_i    = TW'(tag);
        pending  = e;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, model(0, 0, 0, 0, 0));
    endtask

    // one clock: sample just after the negedge drive, account transfers at posedge, return at negedge
    task automatic cycle(output bit acc);
        bit   con;
        exp_t cur, e;
        #1;
        acc = valid_i && ready_o;
        con = valid_o && ready_i;
        cur = '{x: x_o, y: y_o, sel: select_o, tag: tag_o};
        if (held) begin
            chk("hold_x", 32'(x_o), 32'(held_v.x));
            chk("hold_y", 32'(y_o), 32'(held_v.y));
            chk("hold_tag", 32'(tag_o), 32'(held_v.tag));
        end
        held   = valid_o && !ready_i;
        held_v = cur;
        @(posedge clk);
        if (acc) q_exp.push_back(pending);
        if (con) begin
            if (q_exp.size() == 0) chk("spurious_beat", 32'(1), 32'(0));
            else begin
                e = q_exp.pop_front();
                consumed++;
                chk("out_x", 32'(cur.x), 32'(e.x));
                chk("out_y", 32'(cur.y), 32'(e.y));
                chk("out_sel", 32'(cur.sel), 32'(e.sel));
                chk("out_tag", 32'(cur.tag), 32'(e.tag));
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        idle();
        ready_i = 1'b1;
        for (int i = 0; i < 20 && (q_exp.size() > 0 || valid_o); i++) cycle(acc);
        chk("drain_empty", 32'(q_exp.size()), 32'(0));
    endtask

    initial begin
        bit acc;
        int nt, c0, a, wb, q;
        bit sel, h;

        @(negedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 32'(0));
        chk("rst_x", 32'(x_o), 32'(0));
        chk("rst_tag", 32'(tag_o), 32'(0));
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("rst_ready", 32'(ready_o), 32'(1));
        @(negedge clk);

        drive(1, 3000, 500, 0, 0, 8'h11, '{x: 171, y: 2500, sel: 0, tag: 8'h11});
        cycle(acc);
        chk("k_accept", 32'(acc), 32'(1));
        idle();
        chk("k_lat1", 32'(valid_o), 32'(0));
        cycle(acc);
        chk("k_lat2", 32'(valid_o), 32'(1));
        chk("k_x", 32'(x_o), 32'(171));
        chk("k_y", 32'(y_o), 32'(2500));
        drain();

        drive(1, 8380416, 1, 1, 0, 1, '{x: 0, y: 8380415, sel: 1, tag: 1});
        cycle(acc);
        drive(1, 0, 1, 1, 0, 2, '{x: 1, y: 8380416, sel: 1, tag: 2});
        cycle(acc);
        drain();

        drive(1, 0, 1, 0, 0, 3, '{x: 1, y: 3328, sel: 0, tag: 3});
        cycle(acc);
        drive(1, 5, 7, 1, 0, 4, '{x: 12, y: 8380415, sel: 1, tag: 4});
        cycle(acc);
        idle();
        chk("mix_v0", 32'(valid_o), 32'(1));
        chk("mix_x0", 32'(x_o), 32'(1));
        cycle(acc);
        chk("mix_v1", 32'(valid_o), 32'(1));
        chk("mix_x1", 32'(x_o), 32'(12));
        chk("mix_y1", 32'(y_o), 32'(8380415));
        drain();

        nt = 0;
        c0 = consumed;
        for (int i = 0; i < 16; i++) begin
            ready_i = !(i >= 3 && i <= 7);
            if (nt < 10) drive(1, nt * 300, nt * 7, 0, 0, nt, model(nt * 300, nt * 7, 0, 0, nt));
            else idle();
            if (i == 5) begin
                #1;
                chk("bp_ready_low", 32'(ready_o), 32'(0));
            end
            cycle(acc);
            if (acc) nt++;
        end
        drain();
        chk("bp_all_tags", 32'(consumed - c0), 32'(10));

`ifdef BFLY_HALVE_EN
        drive(1, 3, 0, 0, 1, 5, '{x: 1666, y: 1666, sel: 0, tag: 5});
        cycle(acc);
        drive(1, 4, 2, 1, 1, 6, '{x: 3, y: 1, sel: 1, tag: 6});
        cycle(acc);
        drain();
`endif

        for (int i = 0; i < 300; i++) begin
            ready_i = ($urandom_range(0, 9) < 7);
            sel = 1'($urandom_range(0, 1));
            q = sel ? QD : QK;
            a = int'($urandom_range(0, q - 1));
            wb = (i % 17 == 0) ? a : int'($urandom_range(0, q - 1));
`ifdef BFLY_HALVE_EN
            h = 1'($urandom_range(0, 1));
`else
            h = 1'b0;
`endif
            if ($urandom_range(0, 9) < 8) drive(1, a, wb, sel, h, i, model(a, wb, sel, h, i));
            else idle();
            cycle(acc);
        end
        drain();

        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 100 + i, 5, 1, 0, 40 + i, model(100 + i, 5, 1, 0, 40 + i));
            cycle(acc);
        end
        idle();
        rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 32'(0));
        chk("mid_rst_x", 32'(x_o), 32'(0));
        chk("mid_rst_y", 32'(y_o), 32'(0));
        chk("mid_rst_tag", 32'(tag_o), 32'(0));
        chk("mid_rst_sel", 32'(select_o), 32'(0));
        q_exp.delete();
        held = 0;
        @(negedge clk);
        rst_i = 1'b0;
        ready_i = 1'b1;
        drive(1, 10, 20, 0, 0, 9, '{x: 30, y: 3319, sel: 0, tag: 9});
        cycle(acc);
        idle();
        chk("post_rst_lat1", 32'(valid_o), 32'(0));
        cycle(acc);
        chk("post_rst_lat2", 32'(valid_o), 32'(1));
        chk("post_rst_tag", 32'(tag_o), 32'(9));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ct_bfly_post.md
Name: ct_bfly_post

Overview:
- Downstream stage of the PE's modular multiplier.
- Consumes the reduced product w*b (mod q) plus the aligned butterfly operand a, and produces the Cooley-Tukey butterfly outputs x = a + w*b mod q and y = a - w*b mod q.
- Two-stage valid/ready pipeline between the multiplier and the coefficient write-back path.
- Supports both moduli: Kyber q = 3329 and Dilithium q = 8380417.

Parameters:
- COEF_W, 23, coefficient width; covers the Dilithium q.
- TAG_W, 8, sideband tag width (e.g. write-back address), carried unmodified.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- valid_i  input  1  input beat valid
- ready_o  output  1  block can accept a beat this cycle
- a_i  input  COEF_W  butterfly operand a, < q
- wb_i  input  COEF_W  reduced product w*b from the multiplier, < q
- select_i  input  1  1 = Dilithium q, 0 = Kyber q (same encoding as the multiplier)
- tag_i  input  TAG_W  sideband tag
- valid_o  output  1  output beat valid
- ready_i  input  1  downstream accepts the output beat
- x_o  output  COEF_W  (a + wb) mod q
- y_o  output  COEF_W  (a - wb) mod q
- select_o  output  1  select_i of this beat
- tag_o  output  TAG_W  tag_i of this beat

Behaviour:
- Reset, asynchronous on rst_i high: both stage valid flags cleared; valid_o=0; x_o, y_o, tag_o, select_o = 0. ready_o=1 from the first cycle after rst_i is deasserted.
- Transfers:
  - An input beat is accepted when valid_i && ready_o.
  - An output beat is consumed when valid_o && ready_i.
- Stage 1 (S1) registers a, wb, select, tag.
- Stage 2 (S2) registers x, y, select, tag; valid_o = S2 valid.
- Advance rules:
  - S2 loads when (!S2.valid || ready_i).
  - S1 loads when (!S1.valid || S2 loads).
  - ready_o = !S1.valid || S2 loads. This is a combinational path from ready_i; no skid buffer.
- Latency: an accepted beat appears on valid_o on the 2nd rising edge after acceptance, with no stalls. Full throughput of 1 beat/cycle while ready_i is held high.
- Bubbles collapse: an empty stage always loads.
- Ordering strictly preserved; no beat dropped or duplicated under any ready_i pattern.
- Outputs x_o, y_o, tag_o, select_o hold stable while valid_o && !ready_i.
- Arithmetic, computed combinationally between S1 and S2:
  - q = select ? 8380417 : 3329.
  - When select=0, bits [COEF_W-1:12] of a and wb are ignored (treated as 0) and outputs have those bits = 0.
  - sum = a + wb at COEF_W+1 bits; x = (sum >= q) ? sum - q : sum.
  - diff = a - wb at COEF_W+1 bits, signed; y = (diff < 0) ? diff + q : diff.
  - Only a single conditional correction is applied. Inputs >= q are a protocol violation and the outputs are then unspecified.
- select is per beat: mixed Kyber/Dilithium streams are legal back to back.
- Reset mid-operation discards every in-flight beat; no partial output.

Optional Feature:
- Macro: BFLY_HALVE_EN.
- When defined:
  - Extra input port halve_i (1 bit), sampled with valid_i and carried through S1.
  - When halve=1, both x and y are additionally multiplied by 2^-1 mod q in S2: v even -> v>>1; v odd -> (v+q)>>1. This is used for inverse NTT scaling.
  - Latency unchanged.
- When undefined: the port is absent and no halving logic is present.

Decomposition:
- Shared package pe_pkg:
  - Constants Q_KYBER=3329, Q_DILITHIUM=8380417, COEF_W=23.
  - Enum alg_t {ALG_KYBER=0, ALG_DILITHIUM=1}, matching the select encoding.
  - Function q_of(alg_t).
- One natural sub-module: mod_addsub. Combinational; inputs a, b, select; outputs (a+b) mod q and (a-b) mod q. Instantiated once between S1 and S2 and reusable by the Gentleman-Sande path.

Test Plan:
- Kyber: select=0, a=3000, wb=500, ready_i=1 -> 2 cycles later x_o=171, y_o=2500, tag_o echoed.
- Dilithium: select=1, a=8380416, wb=1 -> x_o=0, y_o=8380415. Then a=0, wb=1 -> x_o=1, y_o=8380416.
- Mixed stream, one beat per cycle:
  - Kyber (a=0, wb=1) -> x=1, y=3328.
  - Dilithium (a=5, wb=7) -> x=12, y=8380415.
  - Outputs arrive in order on consecutive cycles.
- Backpressure: continuous valid_i with tags 0..9; ready_i low for cycles 3-7.
  - ready_o falls once S1 and S2 are full.
  - All 10 tags emerge exactly once, in order, with held outputs stable while stalled.
- Reset: rst_i pulsed while both stages are full -> valid_o=0 and outputs zero immediately (asynchronously); first post-reset beat emerges with 2-cycle latency.
- BFLY_HALVE_EN: Kyber a=3, wb=0, halve=1 -> x_o=1666, y_o=1666. Dilithium a=4, wb=2, halve=1 -> x_o=3, y_o=1.
